univ_shift_reg_n: RTL and testbench
===================================

# univ_shift_reg_n

Parametrised universal shift register for the datapath utility library, successor to the fixed 4-bit bidirectional shifter. It holds a WIDTH-bit word that can be parallel-loaded, then shifted left or right by a programmable number of positions. The shift mode is selectable: logical with serial fill, rotate, or arithmetic. Multi-step shifts run one position per clock under a start/busy/done handshake, so upstream control logic can issue a shift command and wait for completion.

## Interface
- WIDTH, 8, register width in bits (≥2)
- CNT_W, 4, width of step-count input; max shift per command is 2^CNT_W−1
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- load  input  1  parallel load request (IDLE only)
- d_in  input  WIDTH  parallel load data
- start  input  1  shift command strobe (IDLE only)
- dir  input  1  0 = shift right (toward bit 0), 1 = shift left; latched at start
- mode  input  2  00 logical, 01 rotate, 10 arithmetic, 11 logical zero-fill; latched at start
- steps  input  CNT_W  number of single-position shifts; latched at start
- ser_in  input  1  serial fill bit for mode 00, sampled live on every shift edge
- q  output  WIDTH  register contents
- ser_out  output  1  registered copy of the bit discarded or rotated out by the most recent shift
- busy  output  1  high while a shift command is executing
- done  output  1  one-cycle pulse when a command completes

## Operation
- States: IDLE, SHIFT. A remaining-step counter is CNT_W bits wide.
- In IDLE, q holds unless load or start is asserted.
- IDLE with load=1 sets q<=d_in. Load has priority: if load and start are both high, start is ignored.
- IDLE with start=1 and load=0 latches dir, mode and steps.
  - steps≠0: go to SHIFT with remaining<=steps.
  - steps=0: stay in IDLE, assert done next cycle, leave q unchanged.
- SHIFT: each edge performs exactly one shift and decrements remaining. On the edge where remaining==1, perform the final shift, return to IDLE and set done<=1.
- Shift rules, right (dir=0); the MSB is filled as follows, and ser_out<=q[0]:
  - 00: MSB<=ser_in
  - 01: MSB<=q[0]
  - 10: MSB<=q[WIDTH−1]
  - 11: MSB<=0
- Shift rules, left (dir=1); the LSB is filled as follows, and ser_out<=q[WIDTH−1]:
  - 00: LSB<=ser_in
  - 01: LSB<=q[WIDTH−1]
  - 10 and 11: LSB<=0
- While busy, load and start are ignored. Changes on dir, mode or steps have no effect on the running command.
- steps may exceed WIDTH. Logical, arithmetic and zero-fill shifts saturate naturally to fill values. Rotating by a multiple of WIDTH returns the original word.
- done is high for exactly one cycle per accepted start. busy and done are never high together.

## Timing
- Reset: q=0, ser_out=0, busy=0, done=0, state IDLE, remaining=0. Reset takes effect immediately and asynchronously, including mid-command. The aborted command produces no done.
- Load latency: q updates on the edge where load is sampled.
- Start sampled at edge E0 with N≠0:
  - busy is high from after E0 through edge E_N.
  - Shifts occur on edges E1..EN.
  - done is high for the cycle after EN, with busy low in that cycle.
- A new start may be accepted on the edge that ends the done cycle. Throughput is N+1 cycles per command.
- steps=0: done is high the cycle after E0 and busy stays low.

## Test plan
- Reset and load: assert rst_n=0 mid-cycle → q=0, busy=0, done=0 immediately. Then load d_in=0xA5 → q=0xA5 on the next edge.
- Logical right: q=0xA5, start dir=0 mode=00 steps=3 ser_in=0.
  - busy is high for 3 cycles, then done for 1.
  - Result: q=0x14, ser_out=1.
- Rotate left full word: q=0xA5, dir=1 mode=01 steps=8 → q=0xA5 after 8 shifts. An intermediate check after the 4th shift gives q=0x5A.
- Arithmetic right: load 0x96, dir=0 mode=10 steps=2 → q=0xE5. Repeat with steps=0 → done after 1 cycle, q unchanged, busy never high.
- Ignored requests: during a 5-step logical-left shift of 0x01 with ser_in=1, pulse load=1 d_in=0xFF and start=1.
  - Both are ignored.
  - Result: q=0x3F, exactly one done pulse.
- Reset mid-shift: start a 6-step rotate, drop rst_n after 2 shifts → q=0, busy=0, no done pulse. A subsequent load and shift behave normally.

Source files
------------

// File: rtl/univ_shift_reg_n.sv
// Universal shift register: parallel load, then multi-step shifts (logical,
// rotate, arithmetic, zero-fill) in either direction, one position per clock,
// with a start/busy/done handshake for the issuing control logic.
module univ_shift_reg_n #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d_in,
    input  logic             start,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] steps,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic [1:0] MODE_LOGICAL = 2'b00;
    localparam logic [1:0] MODE_ROTATE  = 2'b01;
    localparam logic [1:0] MODE_ARITH   = 2'b10;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] remaining, remaining_nxt;
    logic             dir_q, dir_nxt;
    logic [1:0]       mode_q, mode_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             ser_out_nxt;
    logic             done_nxt;

    // Single-position shift result and the bit pushed out of the word.
    logic [WIDTH-1:0] shift_val;
    logic             fill_bit;
    logic             out_bit;

    // One-position shift of q using the command's latched direction and mode;
    // ser_in is deliberately taken live, not latched.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
        fill_bit  = 1'b0;
        out_bit   = 1'b0;
        shift_val = q;
        if (!dir_q) begin
            out_bit = q[0];
            case (mode_q)
                MODE_LOGICAL: fill_bit = ser_in;
                MODE_ROTATE:  fill_bit = q[0];
                MODE_ARITH:   fill_bit = q[WIDTH-1];
                default:      fill_bit = 1'b0;
            endcase
            shift_val = {fill_bit, q[WIDTH-1:1]};
        end else begin
            out_bit = q[WIDTH-1];
            case (mode_q)
                MODE_LOGICAL: fill_bit = ser_in;
                MODE_ROTATE:  fill_bit = q[WIDTH-1];
                default:      fill_bit = 1'b0;
            endcase
            shift_val = {q[WIDTH-2:0], fill_bit};
        end
    end

    // Next-state logic: load/start accepted only in IDLE, load wins over start;
    // SHIFT performs one shift per edge until the remaining count runs out.
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        dir_nxt       = dir_q;
        mode_nxt      = mode_q;
        q_nxt         = q;
        ser_out_nxt   = ser_out;
        done_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    q_nxt = d_in;
                end else if (start) begin
                    dir_nxt  = dir;
                    mode_nxt = mode;
                    if (steps != '0) begin
                        state_nxt     = SHIFT;
                        remaining_nxt = steps;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            SHIFT: begin
                q_nxt         = shift_val;
                ser_out_nxt   = out_bit;
                remaining_nxt = remaining - 1'b1;
                if (remaining == CNT_W'(1)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any command without a done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            dir_q     <= 1'b0;
            mode_q    <= 2'b00;
            q         <= '0;
            ser_out   <= 1'b0;
            done      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state     <= state_nxt;
            remaining <= remaining_nxt;
            dir_q     <= dir_nxt;
            mode_q    <= mode_nxt;
            q         <= q_nxt;
            ser_out   <= ser_out_nxt;
            done      <= done_nxt;
        end
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// Directed bench for univ_shift_reg_n with hand-computed expected values.
module tb_univ_shift_reg_n;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] d_in = '0;
    logic             start = 1'b0;
    logic             dir = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic [CNT_W-1:0] steps = '0;
    logic             ser_in = 1'b0;
    logic [WIDTH-1:0] q;
    logic             ser_out;
    logic             busy;
    logic             done;

    int n_tests = 0;
    int n_fail  = 0;

    univ_shift_reg_n #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .d_in    (d_in),
        .start   (start),
        .dir     (dir),
        .mode    (mode),
        .steps   (steps),
        .ser_in  (ser_in),
        .q       (q),
        .ser_out (ser_out),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advance one clock edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [WIDTH-1:0] val);
        load = 1'b1;
        d_in = val;
        tick();
        load = 1'b0;
    endtask

    // Issue a command on edge E0 and observe 40 cycles afterwards. Index i is
    // the cycle after edge E_i. Optionally pokes load=1/d_in=FF/start=1 at
    // cycle index poke (-1 = never).
    task automatic run_cmd(input logic d, input logic [1:0] m, input int n, input int poke,
                           output int busy_n, output int done_n, output int done_at,
                           output int overlap);
        busy_n  = 0;
        done_n  = 0;
        done_at = -1;
        overlap = 0;
        dir   = d;
        mode  = m;
        steps = CNT_W'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        dir   = ~d;
        mode  = ~m;
        steps = '1;
        for (int i = 0; i < 40; i++) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at < 0) done_at = i;
            end
            if (busy && done) overlap++;
            if (i == poke) begin
                load  = 1'b1;
                d_in  = 8'hFF;
                start = 1'b1;
            end else begin
                load  = 1'b0;
                start = 1'b0;
            end
            tick();
        end
    endtask

    initial begin
        int bn, dn, da, ov;

        // Reset and load
        #12;
        check("reset_q", 32'(q), 32'h00);
        rst_n = 1'b1;
        tick();
        do_load(8'h3C);
        check("load_3c", 32'(q), 32'h3C);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_q", 32'(q), 32'h00);
        check("async_rst_busy", 32'(busy), 32'h0);
        check("async_rst_done", 32'(done), 32'h0);
        check("async_rst_ser_out", 32'(ser_out), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_load(8'hA5);
        check("load_a5", 32'(q), 32'hA5);

        // Logical right 3 of 0xA5, ser_in=0
        ser_in = 1'b0;
        run_cmd(1'b0, 2'b00, 3, -1, bn, dn, da, ov);
        check("lsr_q", 32'(q), 32'h14);
        check("lsr_ser_out", 32'(ser_out), 32'h1);
        check("lsr_busy_cycles", 32'(bn), 32'd3);
        check("lsr_done_count", 32'(dn), 32'd1);
        check("lsr_done_at", 32'(da), 32'd3);
        check("lsr_overlap", 32'(ov), 32'd0);

        // Rotate left by 4 then full word
        do_load(8'hA5);
        dir = 1'b1; mode = 2'b01; steps = 4'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        steps = 4'd1;
        for (int i = 0; i < 4; i++) tick();
        check("rol_mid_q", 32'(q), 32'h5A);
        check("rol_mid_busy", 32'(busy), 32'h1);
        for (int i = 0; i < 4; i++) tick();
        check("rol_full_q", 32'(q), 32'hA5);
        check("rol_full_ser_out", 32'(ser_out), 32'h1);
        check("rol_full_done", 32'(done), 32'h1);
        check("rol_full_busy", 32'(busy), 32'h0);
        tick();
        check("rol_done_drop", 32'(done), 32'h0);

        // Arithmetic right 2 of 0x96, then steps=0
        do_load(8'h96);
        run_cmd(1'b0, 2'b10, 2, -1, bn, dn, da, ov);
        check("asr_q", 32'(q), 32'hE5);
        check("asr_ser_out", 32'(ser_out), 32'h1);
        check("asr_busy_cycles", 32'(bn), 32'd2);
        run_cmd(1'b0, 2'b10, 0, -1, bn, dn, da, ov);
        check("zero_q", 32'(q), 32'hE5);
        check("zero_busy_cycles", 32'(bn), 32'd0);
        check("zero_done_count", 32'(dn), 32'd1);
        check("zero_done_at", 32'(da), 32'd0);

        // Ignored load/start during a 5-step logical-left of 0x01
        do_load(8'h01);
        ser_in = 1'b1;
        run_cmd(1'b1, 2'b00, 5, 1, bn, dn, da, ov);
        check("ign_q", 32'(q), 32'h3F);
        check("ign_ser_out", 32'(ser_out), 32'h0);
        check("ign_done_count", 32'(dn), 32'd1);
        check("ign_busy_cycles", 32'(bn), 32'd5);
        check("ign_overlap", 32'(ov), 32'd0);
        ser_in = 1'b0;

        // Left zero-fill with steps beyond width saturates to zero
        do_load(8'hFF);
        run_cmd(1'b1, 2'b11, 12, -1, bn, dn, da, ov);
        check("zfl_sat_q", 32'(q), 32'h00);
        check("zfl_busy_cycles", 32'(bn), 32'd12);

        // Reset mid-shift: 6-step rotate aborted after 2 shifts
        do_load(8'hA5);
        dir = 1'b0; mode = 2'b01; steps = 4'd6;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("abort_pre_q", 32'(q), 32'h69);
        #2 rst_n = 1'b0;
        #1;
        check("abort_q", 32'(q), 32'h00);
        check("abort_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) dn++;
        end
        check("abort_no_done", 32'(dn), 32'd0);
        do_load(8'h0F);
        run_cmd(1'b0, 2'b11, 1, -1, bn, dn, da, ov);
        check("post_abort_q", 32'(q), 32'h07);
        check("post_abort_ser_out", 32'(ser_out), 32'h1);
        check("post_abort_done_count", 32'(dn), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
